// File: rtl/knap_search_ctrl.sv
// knap_search_ctrl
//   Exhaustive-search scheduler for a combinational knapsack checker.
//   It presents every selection 0 .. 2^N_ITEMS-1, one per cycle, registers the
//   checker verdict one cycle later, and keeps the best valid selection (by
//   value, lowest index on ties) together with the number of valid selections.
//   Optional feature macro: EARLY_EXIT_EN stops at the first valid selection.
module knap_search_ctrl #(
   parameter int N_ITEMS = 10,
   parameter int VAL_W   = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic               abort_i,
   output logic [N_ITEMS-1:0] cand_o,
   output logic               cand_en_o,
   input  logic               chk_valid_i,
   input  logic [VAL_W-1:0]   chk_value_i,
   output logic               busy_o,
   output logic               done_o,
   output logic               best_found_o,
   output logic [N_ITEMS-1:0] best_sel_o,
   output logic [VAL_W-1:0]   best_value_o,
   output logic [N_ITEMS:0]   sol_count_o
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t             state_q, state_d;
   logic [N_ITEMS-1:0] cand_q, cand_d;
   logic               cand_en_q, cand_en_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               s_pend_q, s_pend_d;
   logic [N_ITEMS-1:0] s_sel_q, s_sel_d;
   logic               s_valid_q, s_valid_d;
   logic [VAL_W-1:0]   s_value_q, s_value_d;

   logic               best_found_q, best_found_d;
   logic [N_ITEMS-1:0] best_sel_q, best_sel_d;
   logic [VAL_W-1:0]   best_value_q, best_value_d;
   logic [N_ITEMS:0]   sol_count_q, sol_count_d;

   logic               do_update;

   localparam logic [N_ITEMS-1:0] CAND_ONE  = {{(N_ITEMS-1){1'b0}}, 1'b1};
   localparam logic [N_ITEMS:0]   COUNT_ONE = {{N_ITEMS{1'b0}}, 1'b1};

   // Next-state logic: sequencing, stage capture, best/count tracking and the registered status flags
   always_comb begin
      state_d      = state_q;
      cand_d       = cand_q;
      s_pend_d     = 1'b0;
      s_sel_d      = s_sel_q;
      s_valid_d    = s_valid_q;
      s_value_d    = s_value_q;
      best_found_d = best_found_q;
      best_sel_d   = best_sel_q;
      best_value_d = best_value_q;
      sol_count_d  = sol_count_q;

      // A staged verdict is consumed only while searching and only if the search is not being cancelled
      do_update = s_pend_q && s_valid_q && !abort_i &&
                  ((state_q == RUN) || (state_q == DRAIN));

      if (do_update) begin
         sol_count_d = sol_count_q + COUNT_ONE;
         if (!best_found_q || (s_value_q > best_value_q)) begin
            best_found_d = 1'b1;
            best_sel_d   = s_sel_q;
            best_value_d = s_value_q;
         end
      end

      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d      = RUN;
               cand_d       = '0;
               best_found_d = 1'b0;
               best_sel_d   = '0;
               best_value_d = '0;
               sol_count_d  = '0;
            end
         end
         RUN: begin
            if (abort_i) begin
               state_d = IDLE;
            end
`ifdef EARLY_EXIT_EN
            else if (do_update) begin
               state_d = DONE;
            end
`endif
            else begin
               s_pend_d  = 1'b1;
               s_sel_d   = cand_q;
               s_valid_d = chk_valid_i;
               s_value_d = chk_value_i;
               if (&cand_q) begin
                  state_d = DRAIN;
               end else begin
                  cand_d = cand_q + CAND_ONE;
               end
            end
         end
         DRAIN: begin
            if (abort_i) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      cand_en_d = (state_d == RUN);
      busy_d    = (state_d == RUN) || (state_d == DRAIN);
      done_d    = (state_d == DONE);
   end

   // State, stage and result registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         cand_q       <= '0;
         cand_en_q    <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         s_pend_q     <= 1'b0;
         s_sel_q      <= '0;
         s_valid_q    <= 1'b0;
         s_value_q    <= '0;
         best_found_q <= 1'b0;
         best_sel_q   <= '0;
         best_value_q <= '0;
         sol_count_q  <= '0;
      end else begin
         state_q      <= state_d;
         cand_q       <= cand_d;
         cand_en_q    <= cand_en_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         s_pend_q     <= s_pend_d;
         s_sel_q      <= s_sel_d;
         s_valid_q    <= s_valid_d;
         s_value_q    <= s_value_d;
         best_found_q <= best_found_d;
         best_sel_q   <= best_sel_d;
         best_value_q <= best_value_d;
         sol_count_q  <= sol_count_d;
      end
   end

   assign cand_o       = cand_q;
   assign cand_en_o    = cand_en_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign best_found_o = best_found_q;
   assign best_sel_o   = best_sel_q;
   assign best_value_o = best_value_q;
   assign sol_count_o  = sol_count_q;

endmodule

// File: tb/tb_knap_search_ctrl.sv
// tb_knap_search_ctrl
//   Bench for knap_search_ctrl with N_ITEMS=4 and a mock checker selected by
//   checkerMode. Fixed checker patterns come from a vector table; random
//   checker tables are scored by a plain enumeration model.
module tb_knap_search_ctrl;

   localparam int N     = 4;
   localparam int VW    = 8;
   localparam int NSEL  = 1 << N;

   logic          clk;
   logic          rst;
   logic          start;
   logic          abort;
   logic [N-1:0]  cand;
   logic          candEn;
   logic          chkValid;
   logic [VW-1:0] chkValue;
   logic          busy;
   logic          done;
   logic          bestFound;
   logic [N-1:0]  bestSel;
   logic [VW-1:0] bestValue;
   logic [N:0]    solCount;

   int checkerMode;
   bit rndValid [NSEL];
   int rndValue [NSEL];

   int totalChecks;
   int passCount;

   typedef struct {
      int mode;
      int found;
      int sel;
      int value;
      int count;
      int doneAt;
   } vec_t;

   vec_t vecs [4];

   knap_search_ctrl #(.N_ITEMS(N), .VAL_W(VW)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .start_i      (start),
      .abort_i      (abort),
      .cand_o       (cand),
      .cand_en_o    (candEn),
      .chk_valid_i  (chkValid),
      .chk_value_i  (chkValue),
      .busy_o       (busy),
      .done_o       (done),
      .best_found_o (bestFound),
      .best_sel_o   (bestSel),
      .best_value_o (bestValue),
      .sol_count_o  (solCount)
   );

   // Free-running clock, 10 time units per cycle
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic bit mockValid(input int m, input int c);
      logic [N-1:0] bits;
      bits = c[N-1:0];
      case (m)
         0:       return $countones(bits) == 2;
         1:       return 1'b0;
         2:       return 1'b1;
         3:       return c >= 3;
         default: return rndValid[c];
      endcase
   endfunction

   function automatic int mockValue(input int m, input int c);
      case (m)
         2:       return 5;
         4:       return rndValue[c];
         default: return c;
      endcase
   endfunction

   // Mock combinational checker driven by the presented candidate
   always_comb begin
      chkValid = mockValid(checkerMode, int'(cand));
      chkValue = VW'(mockValue(checkerMode, int'(cand)));
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      totalChecks++;
      if (actual == expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Enumerate every selection in order; best keeps the first highest value
   task automatic modelSearch(input int m, output vec_t e);
      int first;
      e.mode   = m;
      e.found  = 0;
      e.sel    = 0;
      e.value  = 0;
      e.count  = 0;
      e.doneAt = NSEL + 2;
      first    = -1;
      for (int c = 0; c < NSEL; c++) begin
         if (mockValid(m, c)) begin
            if (first < 0) first = c;
            e.count++;
            if (e.found == 0 || mockValue(m, c) > e.value) begin
               e.found = 1;
               e.sel   = c;
               e.value = mockValue(m, c);
            end
         end
      end
`ifdef EARLY_EXIT_EN
      if (first >= 0) begin
         e.sel    = first;
         e.value  = mockValue(m, first);
         e.count  = 1;
         e.doneAt = first + 3;
      end
`endif
   endtask

   task automatic applyStimulus(input string tag, input vec_t e, input bit holdStart);
      int doneCycle;
      int pulses;
      int candErrs;
      checkerMode = e.mode;
      doneCycle   = -1;
      pulses      = 0;
      candErrs    = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      if (!holdStart) start = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (done) begin
            pulses++;
            if (doneCycle < 0) doneCycle = k;
            start = 1'b0;
         end
         if (k <= e.doneAt - 2) begin
            if (int'(cand) != k - 1 || candEn !== 1'b1) candErrs++;
         end
      end
      start = 1'b0;
      checkOutput({tag, " doneCycle"}, doneCycle, e.doneAt);
      checkOutput({tag, " donePulses"}, pulses, 1);
      checkOutput({tag, " candSequence"}, candErrs, 0);
      checkOutput({tag, " busy"}, int'(busy), 0);
      checkOutput({tag, " bestFound"}, int'(bestFound), e.found);
      checkOutput({tag, " bestSel"}, int'(bestSel), e.sel);
      checkOutput({tag, " bestValue"}, int'(bestValue), e.value);
      checkOutput({tag, " solCount"}, int'(solCount), e.count);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " cand"}, int'(cand), 0);
      checkOutput({tag, " candEn"}, int'(candEn), 0);
      checkOutput({tag, " busy"}, int'(busy), 0);
      checkOutput({tag, " done"}, int'(done), 0);
      checkOutput({tag, " bestFound"}, int'(bestFound), 0);
      checkOutput({tag, " bestSel"}, int'(bestSel), 0);
      checkOutput({tag, " bestValue"}, int'(bestValue), 0);
      checkOutput({tag, " solCount"}, int'(solCount), 0);
   endtask

   // Main test sequence
   initial begin
      vec_t e;
      int   doneSeen;
      totalChecks = 0;
      passCount   = 0;
      checkerMode = 1;
      start       = 1'b0;
      abort       = 1'b0;
      rst         = 1'b1;
      for (int c = 0; c < NSEL; c++) begin
         rndValid[c] = 1'b0;
         rndValue[c] = 0;
      end

`ifdef EARLY_EXIT_EN
      vecs[0] = '{mode: 0, found: 1, sel: 3,  value: 3,  count: 1,  doneAt: 6};
      vecs[1] = '{mode: 1, found: 0, sel: 0,  value: 0,  count: 0,  doneAt: 18};
      vecs[2] = '{mode: 2, found: 1, sel: 0,  value: 5,  count: 1,  doneAt: 3};
      vecs[3] = '{mode: 3, found: 1, sel: 3,  value: 3,  count: 1,  doneAt: 6};
`else
      vecs[0] = '{mode: 0, found: 1, sel: 12, value: 12, count: 6,  doneAt: 18};
      vecs[1] = '{mode: 1, found: 0, sel: 0,  value: 0,  count: 0,  doneAt: 18};
      vecs[2] = '{mode: 2, found: 1, sel: 0,  value: 5,  count: 16, doneAt: 18};
      vecs[3] = '{mode: 3, found: 1, sel: 15, value: 15, count: 13, doneAt: 18};
`endif

      repeat (2) @(posedge clk);
      @(negedge clk);
      checkAllZero("reset");
      rst = 1'b0;

      for (int i = 0; i < 4; i++) begin
         applyStimulus($sformatf("vec%0d", i), vecs[i], 1'b0);
      end

      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < NSEL; c++) begin
            rndValid[c] = ($urandom_range(0, 3) <= r);
            rndValue[c] = (r == 2) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255));
         end
         modelSearch(4, e);
         applyStimulus($sformatf("rnd%0d", r), e, 1'b0);
      end

`ifndef EARLY_EXIT_EN
      // Abort five cycles into an all-valid search: three verdicts applied, the fourth discarded
      checkerMode = 2;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      @(negedge clk);
      checkOutput("abort busy", int'(busy), 0);
      checkOutput("abort candEn", int'(candEn), 0);
      checkOutput("abort solCount", int'(solCount), 3);
      checkOutput("abort bestSel", int'(bestSel), 0);
      checkOutput("abort bestValue", int'(bestValue), 5);
      doneSeen = 0;
      for (int k = 0; k < 25; k++) begin
         @(negedge clk);
         if (done || busy) doneSeen++;
      end
      checkOutput("abort noDone", doneSeen, 0);
`endif

      applyStimulus("restart", vecs[0], 1'b0);
      applyStimulus("holdStart", vecs[3], 1'b1);

      // Reset in the middle of a search clears every output on that edge
      checkerMode = 2;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkAllZero("midReset");
      rst = 1'b0;

      $display("[TB] %0d/%0d checks passed", passCount, totalChecks);
      $finish;
   end

endmodule
